// File: rtl/memory_copier.sv
// Word-by-word memory copier: READ, CAPTURE, WRITE per word (3 cycles), one-cycle done pulse.
// Optional running checksum of written words when MEMORY_COPIER_CHECKSUM_EN is defined.
module memory_copier #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 32,
  parameter int LENGTH_WIDTH  = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] sourceAddress,
  input  logic [ADDRESS_WIDTH-1:0] destinationAddress,
  input  logic [LENGTH_WIDTH-1:0]  length,
  output logic                     busy,
  output logic                     done,
  output logic [ADDRESS_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0]    dataOut,
  input  logic [DATA_WIDTH-1:0]    dataIn,
  output logic                     readEnabled,
  output logic                     writeEnabled
`ifdef MEMORY_COPIER_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0]    checksum
`endif
);

  // Memory handshake: a strobe is a one-cycle request with address/dataOut valid in
  // that same cycle; read data returns on dataIn the following cycle (CAPTURE).
  typedef enum logic [2:0] {IDLE, READ, CAPTURE, WRITE, DONE} state_t;

  state_t                   state;
  state_t                   state_next;
  logic [ADDRESS_WIDTH-1:0] src_q;
  logic [ADDRESS_WIDTH-1:0] dst_q;
  logic [LENGTH_WIDTH-1:0]  len_q;
  logic [LENGTH_WIDTH-1:0]  index;
  logic [DATA_WIDTH-1:0]    buffer;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]    dout_q;
  logic [ADDRESS_WIDTH-1:0] index_addr;
  logic [LENGTH_WIDTH:0]    index_inc;
  logic                     last_word;

  // Index is widened by one bit so index+1 never overflows in the compare.
  assign index_addr = ADDRESS_WIDTH'(index);
  assign index_inc  = {1'b0, index} + (LENGTH_WIDTH+1)'(1);
  assign last_word  = index_inc >= {1'b0, len_q};

  always_comb begin
    state_next   = state;
    busy         = (state != IDLE);
    done         = 1'b0;
    readEnabled  = 1'b0;
    writeEnabled = 1'b0;
    address      = addr_q;
    dataOut      = dout_q;
    unique case (state)
      IDLE: begin
        if (start) state_next = (length == '0) ? DONE : READ;
      end
      READ: begin
        readEnabled = 1'b1;
        address     = src_q + index_addr;
        state_next  = CAPTURE;
      end
      CAPTURE: state_next = WRITE;
      WRITE: begin
        writeEnabled = 1'b1;
        address      = dst_q + index_addr;
        dataOut      = buffer;
        state_next   = last_word ? DONE : READ;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      index    <= '0;
      buffer   <= '0;
      addr_q   <= '0;
      dout_q   <= '0;
`ifdef MEMORY_COPIER_CHECKSUM_EN
      checksum <= '0;
`endif
    end else begin
      state  <= state_next;
      // Hold registers keep address/dataOut stable while both strobes are low.
      addr_q <= address;
      dout_q <= dataOut;
      case (state)
        IDLE: begin
          if (start) begin
            src_q    <= sourceAddress;
            dst_q    <= destinationAddress;
            len_q    <= length;
            index    <= '0;
`ifdef MEMORY_COPIER_CHECKSUM_EN
            checksum <= '0;
`endif
          end
        end
        CAPTURE: buffer <= dataIn;
        WRITE: begin
          index    <= index + LENGTH_WIDTH'(1);
`ifdef MEMORY_COPIER_CHECKSUM_EN
          checksum <= checksum + buffer;
`endif
        end
        default: ;
      endcase
    end
  end

  a_strobes_exclusive: assert property (@(posedge clock) !(readEnabled && writeEnabled));
  a_busy_state: assert property (@(posedge clock) busy == (state != IDLE));

endmodule

// File: tb/tb_memory_copier.sv
// Self-checking bench for memory_copier: memory slave, reference copy model, scoreboard queues.
// Build with MEMORY_COPIER_CHECKSUM_EN to also check the checksum output.
module tb_memory_copier;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] sourceAddress = '0;
  logic [15:0] destinationAddress = '0;
  logic [15:0] length = '0;
  logic        busy;
  logic        done;
  logic [15:0] address;
  logic [31:0] dataOut;
  logic [31:0] dataIn = '0;
  logic        readEnabled;
  logic        writeEnabled;
`ifdef MEMORY_COPIER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  memory_copier dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .sourceAddress(sourceAddress),
    .destinationAddress(destinationAddress),
    .length(length),
    .busy(busy),
    .done(done),
    .address(address),
    .dataOut(dataOut),
    .dataIn(dataIn),
    .readEnabled(readEnabled),
    .writeEnabled(writeEnabled)
`ifdef MEMORY_COPIER_CHECKSUM_EN
    ,
    .checksum(checksum)
`endif
  );

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  // ---------------- memory slave and reference ----------------
  logic [31:0] mem     [0:65535];
  logic [31:0] ref_mem [0:65535];

  always @(posedge clock) begin
    if (readEnabled) dataIn <= mem[address];
    if (writeEnabled) mem[address] <= dataOut;
  end

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [15:0] rd_q[$];
  logic [47:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (readEnabled && writeEnabled) check("strobes_exclusive", 64'd1, 64'd0);
    if (readEnabled) begin
      if (rd_q.size() == 0) check("read_unexpected", {48'd0, address}, 64'hdead);
      else check("read_addr", {48'd0, address}, {48'd0, rd_q.pop_front()});
    end
    if (writeEnabled) begin
      if (exp_q.size() == 0) check("write_unexpected", {16'd0, address, dataOut}, 64'hdead);
      else check("write_addr_data", {16'd0, address, dataOut}, {16'd0, exp_q.pop_front()});
    end
  end

  // ---------------- driver ----------------
  // mode 0: plain copy; mode 1: start re-pulsed at cycle 5; mode 2: reset asserted at cycle 5.
  task automatic run_copy(input logic [15:0] src, input logic [15:0] dst, input int len,
                          input int mode);
    int          abort_cyc;
    int          exp_strobes;
    int          strobes;
    int          done_cyc;
    int          exp_done;
    logic [31:0] sum;
    logic [31:0] w;
    logic        exp_busy;
    abort_cyc   = (mode == 2) ? 5 : 1000000;
    exp_done    = (mode == 2) ? -1 : 3 * len + 1;
    exp_strobes = 0;
    sum         = '0;
    // Reference copy: ascending words, each read sees every earlier write.
    for (int i = 0; i < len; i++) begin
      if (3 * i + 1 < abort_cyc) begin
        rd_q.push_back(src + 16'(i));
        exp_strobes++;
      end
      if (3 * i + 3 < abort_cyc) begin
        w = ref_mem[src + 16'(i)];
        ref_mem[dst + 16'(i)] = w;
        exp_q.push_back({dst + 16'(i), w});
        sum += w;
        exp_strobes++;
      end
    end

    @(negedge clock);
    start              = 1'b1;
    sourceAddress      = src;
    destinationAddress = dst;
    length             = 16'(len);
    @(posedge clock);
    #1;
    start              = 1'b0;
    sourceAddress      = 16'($urandom);
    destinationAddress = 16'($urandom);
    length             = 16'($urandom);

    strobes  = 0;
    done_cyc = 0;
    for (int k = 1; k <= 3 * len + 4; k++) begin
      @(negedge clock);
      exp_busy = (mode == 2) ? (k < 6) : (k <= 3 * len + 1);
      check("busy", {63'd0, busy}, {63'd0, exp_busy});
      check("done", {63'd0, done}, {63'd0, (k == exp_done)});
      if (readEnabled || writeEnabled) strobes++;
`ifdef MEMORY_COPIER_CHECKSUM_EN
      if (k == exp_done || k == 3 * len + 4)
        check("checksum", {32'd0, checksum}, {32'd0, (mode == 2) ? 32'd0 : sum});
`endif
      if (mode == 1 && k == 5) begin
        start              = 1'b1;
        sourceAddress      = 16'($urandom);
        destinationAddress = 16'($urandom);
        length             = 16'($urandom_range(1, 8));
      end
      if (mode == 1 && k == 6) start = 1'b0;
      if (mode == 2 && k == 5) reset = 1'b0;
      if (mode == 2 && k == 6) begin
        check("abort_outputs", {45'd0, busy, done, readEnabled, writeEnabled, address},
              64'd0);
        check("abort_dataout", {32'd0, dataOut}, 64'd0);
        reset = 1'b1;
      end
    end
    check("strobe_count", 64'(strobes), 64'(exp_strobes));
    check("reads_drained", 64'(rd_q.size()), 64'd0);
    check("writes_drained", 64'(exp_q.size()), 64'd0);
    rd_q.delete();
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] s;
    logic [15:0] d;
    for (int a = 0; a < 65536; a++) begin
      mem[a]     = $urandom;
      ref_mem[a] = mem[a];
    end
    for (int i = 0; i < 4; i++) begin
      mem[16'h0010 + i]     = 32'(i + 1);
      ref_mem[16'h0010 + i] = 32'(i + 1);
    end

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_outputs", {45'd0, busy, done, readEnabled, writeEnabled, address}, 64'd0);
    check("reset_dataout", {32'd0, dataOut}, 64'd0);
`ifdef MEMORY_COPIER_CHECKSUM_EN
    check("reset_checksum", {32'd0, checksum}, 64'd0);
`endif
    reset = 1'b1;
    repeat (2) @(negedge clock);

    run_copy(16'h0010, 16'h0100, 4, 0);
    for (int i = 0; i < 4; i++) check("basic_copy_mem", {32'd0, mem[16'h0100 + i]}, 64'(i + 1));
    run_copy(16'h0020, 16'h0030, 0, 0);
    run_copy(16'hFFFE, 16'h0000, 3, 0);
    run_copy(16'h0500, 16'h0501, 4, 0);
    run_copy(16'h0040, 16'h0080, 4, 1);
    run_copy(16'h0200, 16'h0300, 4, 2);
    run_copy(16'h0200, 16'h0300, 4, 0);

    for (int n = 0; n < 12; n++) begin
      s = 16'($urandom);
      d = ($urandom_range(0, 2) == 0) ? s + 16'($urandom_range(0, 3)) : 16'($urandom);
      run_copy(s, d, $urandom_range(1, 8), 0);
    end

    for (int a = 0; a < 65536; a++) begin
      if (mem[a] !== ref_mem[a]) check("final_memory", {32'd0, mem[a]}, {32'd0, ref_mem[a]});
    end
    check("final_memory_word", {32'd0, mem[16'h0103]}, {32'd0, ref_mem[16'h0103]});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
